// File: rtl/sample_link_pkg.sv
// Shared types and symbol constants for the sample_link byte transmitter.
// The PAR state is only reachable when SAMPLE_LINK_PARITY_EN is defined.
package sample_link_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_D0,
    ST_D1,
    ST_D2,
    ST_D3,
    ST_PAR,
    ST_TURN,
    ST_WAIT_ACK
  } state_t;

  localparam logic [1:0] SYM_START   = 2'b10;
  localparam logic [1:0] SYM_ACK     = 2'b01;
  localparam logic [1:0] SYM_NAK     = 2'b10;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_NAK     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // Symbol placed on the bus while in state st; data pairs go MSB first.
  function automatic logic [1:0] beat_for(input state_t st, input logic [7:0] d);
    logic [1:0] sym;
    sym = 2'b00;
    case (st)
      ST_START: sym = SYM_START;
      ST_D0:    sym = d[7:6];
      ST_D1:    sym = d[5:4];
      ST_D2:    sym = d[3:2];
      ST_D3:    sym = d[1:0];
      ST_PAR:   sym = {^d, 1'b0};
      default:  sym = 2'b00;
    endcase
    return sym;
  endfunction

  function automatic logic drives_bus(input state_t st);
    return (st == ST_START) || (st == ST_D0) || (st == ST_D1) ||
           (st == ST_D2)    || (st == ST_D3) || (st == ST_PAR);
  endfunction

endpackage

// File: rtl/sample_link_if.sv
// Byte handshake and status bundle between a byte source and sample_link_tx.
interface sample_link_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, done, err, err_code
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, done, err, err_code
  );
endinterface

// File: rtl/sample_link_ack_timer.sv
// Saturating WAIT_ACK timer; expired is high in the last cycle before timeout.
module sample_link_ack_timer #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] LIMIT = TW'(ACK_TIMEOUT);
  localparam logic [TW-1:0] LAST  = TW'(ACK_TIMEOUT - 1);

  logic [TW-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en && (count_reg != LIMIT)) begin
      count_reg <= count_reg + TW'(1);
    end
  end

  // Entry cycle is count 0, so the error edge ends the cycle at ACK_TIMEOUT-1.
  assign expired = en && (count_reg >= LAST);

endmodule

// File: rtl/sample_link_tx.sv
// Initiator for the 2-bit half-duplex e link: START + four data beats, then ACK/NAK wait.
// Define SAMPLE_LINK_PARITY_EN to append an even-parity PAR beat after D3.
module sample_link_tx
  import sample_link_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int MAX_RETRY   = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  sample_link_if.slave link,
  inout  wire  [1:0]   e,
  output logic         e_oe
);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  state_t        state_reg, state_next;
  logic [7:0]    byte_reg, byte_next;
  logic [RW-1:0] retry_reg, retry_next;
  logic          e_oe_reg, e_oe_next;
  logic [1:0]    e_drv_reg, e_drv_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic          err_reg, err_next;
  logic [1:0]    err_code_reg, err_code_next;

  logic          tx_ready;
  logic          timer_expired;
  logic [1:0]    e_in;

  assign e        = e_oe_reg ? e_drv_reg : 2'bzz;
  assign e_in     = e;
  assign e_oe     = e_oe_reg;
  assign tx_ready = (state_reg == ST_IDLE);

  assign link.tx_ready = tx_ready;
  assign link.busy     = busy_reg;
  assign link.done     = done_reg;
  assign link.err      = err_reg;
  assign link.err_code = err_code_reg;

  sample_link_ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state_reg != ST_WAIT_ACK),
    .en     (state_reg == ST_WAIT_ACK),
    .expired(timer_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      byte_reg     <= '0;
      retry_reg    <= '0;
      e_oe_reg     <= 1'b0;
      e_drv_reg    <= 2'b00;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      err_code_reg <= ERR_NONE;
    end else begin
      state_reg    <= state_next;
      byte_reg     <= byte_next;
      retry_reg    <= retry_next;
      e_oe_reg     <= e_oe_next;
      e_drv_reg    <= e_drv_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
      err_code_reg <= err_code_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    byte_next     = byte_reg;
    retry_next    = retry_reg;
    done_next     = 1'b0;
    err_next      = 1'b0;
    err_code_next = err_code_reg;

    case (state_reg)
      ST_IDLE: begin
        if (link.tx_valid && tx_ready) begin
          byte_next  = link.tx_data;
          retry_next = '0;
          state_next = ST_START;
        end
      end
      ST_START: state_next = ST_D0;
      ST_D0:    state_next = ST_D1;
      ST_D1:    state_next = ST_D2;
      ST_D2:    state_next = ST_D3;
`ifdef SAMPLE_LINK_PARITY_EN
      ST_D3:    state_next = ST_PAR;
`else
      ST_D3:    state_next = ST_TURN;
`endif
      ST_PAR:   state_next = ST_TURN;
      ST_TURN:  state_next = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        // A response seen in the expiry cycle wins over the timeout.
        if (e_in == SYM_ACK) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end else if (e_in == SYM_NAK) begin
          if (retry_reg < RETRY_LIMIT) begin
            retry_next = retry_reg + RW'(1);
            state_next = ST_START;
          end else begin
            state_next    = ST_IDLE;
            err_next      = 1'b1;
            err_code_next = ERR_NAK;
          end
        end else if (timer_expired) begin
          state_next    = ST_IDLE;
          err_next      = 1'b1;
          err_code_next = ERR_TIMEOUT;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Bus outputs are registered from the next state so each beat lines up with its state.
    e_oe_next  = drives_bus(state_next);
    e_drv_next = beat_for(state_next, byte_next);
    busy_next  = (state_next != ST_IDLE);
  end

endmodule

// File: tb/tb_sample_link_tx.sv
// Scoreboard bench for sample_link_tx: stimulus pushes expected beats/pulses, a monitor pops and compares.
`timescale 1ns/1ps
module tb_sample_link_tx;
  import sample_link_pkg::*;

  localparam int ACK_TIMEOUT = 16;
  localparam int MAX_RETRY   = 2;
`ifdef SAMPLE_LINK_PARITY_EN
  localparam int LAT    = 8;
  localparam bit PAR_ON = 1'b1;
`else
  localparam int LAT    = 7;
  localparam bit PAR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sample_link_if link();
  wire  [1:0] e;
  logic       e_oe;
  logic       peer_oe = 1'b0;
  logic [1:0] peer_sym = 2'b00;
  assign e = peer_oe ? peer_sym : 2'bzz;

  sample_link_tx #(
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .MAX_RETRY  (MAX_RETRY)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .link (link),
    .e    (e),
    .e_oe (e_oe)
  );

  typedef struct {
    logic [1:0] sym;
    int         cyc;
  } beat_t;

  typedef struct {
    bit         is_err;
    logic [1:0] code;
    int         cyc;
  } evt_t;

  beat_t beat_q[$];
  evt_t  evt_q[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    r_kind[4];   // 0 = ACK, 1 = NAK, 2 = silent
  int    r_dly[4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h required=%h", name, cyc, got, exp);
    end
  endtask

  // Monitor: every driven beat and every done/err pulse must match the queue head.
  always @(negedge clk) begin
    beat_t b;
    evt_t  ev;
    if (rst_n) begin
      if (e_oe) begin
        checks++;
        if (beat_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat cyc=%0d got=%b required=no_drive", cyc, e);
        end else begin
          b = beat_q.pop_front();
          if (e !== b.sym || cyc != b.cyc) begin
            failures++;
            $display("FAIL bus_beat got=%b@%0d required=%b@%0d", e, cyc, b.sym, b.cyc);
          end else begin
            $display("beat cyc=%0d e=%b ok", cyc, e);
          end
        end
      end
      if (link.done || link.err) begin
        checks++;
        if (evt_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pulse cyc=%0d got=done%b/err%b required=none", cyc, link.done, link.err);
        end else begin
          ev = evt_q.pop_front();
          if (link.done !== !ev.is_err || link.err !== ev.is_err || cyc != ev.cyc ||
              (ev.is_err && link.err_code !== ev.code)) begin
            failures++;
            $display("FAIL pulse got=done%b/err%b/code%b@%0d required=err%b/code%b@%0d",
                     link.done, link.err, link.err_code, cyc, ev.is_err, ev.code, ev.cyc);
          end else begin
            $display("pulse cyc=%0d done=%b err=%b code=%b ok", cyc, link.done, link.err, link.err_code);
          end
        end
      end
    end
  end

  task automatic wait_cycle(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push_frame(input logic [7:0] d, input int s);
    beat_q.push_back('{SYM_START, s});
    for (int i = 0; i < 4; i++) beat_q.push_back('{d[7-2*i -: 2], s + 1 + i});
    if (PAR_ON) beat_q.push_back('{{^d, 1'b0}, s + 5});
  endtask

  // Called at a negedge; offers d and plays the peer per r_kind/r_dly.
  task automatic send(input logic [7:0] d, input int nresp, input bit junk);
    int s, w, k;
    chk("tx_ready_offer", {7'd0, link.tx_ready}, 8'd1);
    link.tx_data  = d;
    link.tx_valid = 1'b1;
    s = cyc + 1;
    push_frame(d, s);
    @(negedge clk);
    link.tx_valid = 1'b0;
    link.tx_data  = ~d;
    for (int i = 0; i < nresp; i++) begin
      w = s + LAT - 1;
      if (r_kind[i] == 2) begin
        evt_q.push_back('{1'b1, ERR_TIMEOUT, w + ACK_TIMEOUT});
        wait_cycle(w + ACK_TIMEOUT);
        break;
      end
      k = w + r_dly[i];
      if (junk) begin
        wait_cycle(w);
        peer_sym = 2'b11;
        peer_oe  = 1'b1;
      end
      wait_cycle(k);
      peer_sym = (r_kind[i] == 0) ? SYM_ACK : SYM_NAK;
      peer_oe  = 1'b1;
      if (r_kind[i] == 0) begin
        evt_q.push_back('{1'b0, ERR_NONE, k + 1});
      end else if (i < MAX_RETRY) begin
        s = k + 1;
        push_frame(d, s);
      end else begin
        evt_q.push_back('{1'b1, ERR_NAK, k + 1});
      end
      @(posedge clk);
      #1 peer_oe = 1'b0;
      @(negedge clk);
      if (r_kind[i] == 0) begin
        chk("tx_ready_after_ack", {7'd0, link.tx_ready}, 8'd1);
        chk("busy_after_ack", {7'd0, link.busy}, 8'd0);
      end
    end
  endtask

  task automatic drain(input logic [1:0] code);
    int n = 0;
    while ((beat_q.size() != 0 || evt_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (beat_q.size() != 0 || evt_q.size() != 0) begin
      failures++;
      $display("FAIL drain cyc=%0d got=beats%0d/pulses%0d pending required=0", cyc, beat_q.size(), evt_q.size());
      beat_q.delete();
      evt_q.delete();
    end
    @(negedge clk);
    chk("idle_tx_ready", {7'd0, link.tx_ready}, 8'd1);
    chk("idle_busy", {7'd0, link.busy}, 8'd0);
    chk("idle_e_oe", {7'd0, e_oe}, 8'd0);
    chk("err_code_hold", {6'd0, link.err_code}, {6'd0, code});
  endtask

  initial begin
    int s;
    link.tx_data  = 8'h00;
    link.tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_e_oe", {7'd0, e_oe}, 8'd0);
    chk("rst_tx_ready", {7'd0, link.tx_ready}, 8'd1);
    chk("rst_busy", {7'd0, link.busy}, 8'd0);
    chk("rst_done", {7'd0, link.done}, 8'd0);
    chk("rst_err", {7'd0, link.err}, 8'd0);
    chk("rst_err_code", {6'd0, link.err_code}, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // B4 ACKed at first sample, then back-to-back C3 with 11 noise before ACK.
    r_kind = '{0, 0, 0, 0}; r_dly = '{0, 0, 0, 0};
    send(8'hB4, 1, 1'b0);
    r_kind = '{0, 0, 0, 0}; r_dly = '{4, 0, 0, 0};
    send(8'hC3, 1, 1'b1);
    drain(ERR_NONE);

    // Two NAKs then ACK.
    r_kind = '{1, 1, 0, 0}; r_dly = '{0, 2, 1, 0};
    send(8'h5A, 3, 1'b0);
    drain(ERR_NONE);

    // NAK every time: retry limit exhausted.
    r_kind = '{1, 1, 1, 0}; r_dly = '{0, 0, 3, 0};
    send(8'h5A, 3, 1'b0);
    drain(ERR_NAK);

    // Silent peer: timeout.
    r_kind = '{2, 0, 0, 0}; r_dly = '{0, 0, 0, 0};
    send(8'h96, 1, 1'b0);
    drain(ERR_TIMEOUT);

    // ACK in the expiry cycle wins; err_code stays from the last error.
    r_kind = '{0, 0, 0, 0}; r_dly = '{ACK_TIMEOUT - 1, 0, 0, 0};
    send(8'h69, 1, 1'b0);
    drain(ERR_TIMEOUT);

    // Reset during D1.
    chk("tx_ready_offer", {7'd0, link.tx_ready}, 8'd1);
    link.tx_data  = 8'h3C;
    link.tx_valid = 1'b1;
    s = cyc + 1;
    beat_q.push_back('{SYM_START, s});
    beat_q.push_back('{2'b00, s + 1});
    @(negedge clk);
    link.tx_valid = 1'b0;
    wait_cycle(s + 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_bus_release", {7'd0, e_oe}, 8'd0);
    chk("reset_busy", {7'd0, link.busy}, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("post_reset_tx_ready", {7'd0, link.tx_ready}, 8'd1);
    chk("post_reset_done", {7'd0, link.done}, 8'd0);
    chk("post_reset_err", {7'd0, link.err}, 8'd0);
    drain(ERR_NONE);

    // Byte 07 after reset; carries a 10 parity beat when parity is built in.
    r_kind = '{0, 0, 0, 0}; r_dly = '{0, 0, 0, 0};
    send(8'h07, 1, 1'b0);
    drain(ERR_NONE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sample_link_tx.md
# sample_link_tx

Byte transmitter for the 2-bit half-duplex `e` link. It is the initiating end of the link whose responder is the `sample` block. It accepts a byte on a valid/ready handshake and sends it as a start symbol followed by four 2-bit data beats. It then releases the bus and waits for the peer's ACK/NAK, retrying on NAK up to a limit. It reports completion or error with single-cycle pulses.

## Interface
- `ACK_TIMEOUT`, 16: cycles spent in WAIT_ACK before a timeout error; minimum 1.
- `MAX_RETRY`, 2: number of retransmissions allowed after NAK; 0 means no retry.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `tx_data`  in  8  byte to send; sampled on accept.
- `tx_valid`  in  1  byte offered.
- `tx_ready`  out  1  block can accept a byte; high only in IDLE.
- `e`  inout  2  link bus; driven only while `e_oe`=1, otherwise high-Z.
- `e_oe`  out  1  bus drive enable; exported for the bench.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a byte is ACKed.
- `err`  out  1  one-cycle pulse on failure.
- `err_code`  out  2  01 = NAK limit exhausted, 10 = timeout; held until the next `err`.

## Operation
- States and transitions:
  - IDLE: `tx_ready`=1. Accept occurs when `tx_valid`&`tx_ready`; the byte is latched, the retry count is cleared, and the state moves to START.
  - START: drives 2'b10; moves to D0.
  - D0..D3: drive `{d[7:6]}`, `{d[5:4]}`, `{d[3:2]}`, `{d[1:0]}` in that order, MSB pair first; then go to PAR if enabled, else TURN.
  - TURN: `e_oe`=0 for one cycle; then WAIT_ACK.
  - WAIT_ACK: bus released; `e` is sampled every cycle and the timer increments.
- Responses in WAIT_ACK:
  - `e`=2'b01 (ACK): go to IDLE and pulse `done`.
  - `e`=2'b10 (NAK): if retry count < MAX_RETRY, increment it and go to START, resending the latched byte. Otherwise go to IDLE, pulse `err`, and set `err_code`=01.
  - `e`=2'b00 or 2'b11: ignored.
  - Timer reaches ACK_TIMEOUT with no ACK/NAK: go to IDLE, pulse `err`, and set `err_code`=10.
- Priority: ACK or NAK seen in the same cycle the timer expires is honoured; timeout loses.
- The latched byte is not changed by `tx_data` activity after accept.
- Timer width is `$clog2(ACK_TIMEOUT+1)`. Retry count width is `$clog2(MAX_RETRY+1)`, minimum 1. Neither counter wraps; the timer saturates.

## Timing
- Reset values: state IDLE, `e_oe`=0 (bus high-Z), `tx_ready`=1, `busy`=0, `done`=0, `err`=0, `err_code`=00, timer and retry count 0.
- Reset mid-frame releases the bus immediately (asynchronous) and discards the byte. No `done` or `err` is produced.
- All outputs are registered except `tx_ready`, which decodes from the state register.
- Accept edge T. START is on the bus in cycle T+1; D0..D3 occupy T+2..T+5. TURN is T+6, or T+7 with parity. The first WAIT_ACK sample is at T+7, or T+8 with parity.
- An ACK sampled in cycle k gives `done`=1, `busy`=0 and `tx_ready`=1 in cycle k+1. A new byte may be accepted in k+1, so back-to-back bytes have no gap.
- A NAK retry sampled in cycle k puts START on the bus in cycle k+1.
- Timeout: the entry cycle of WAIT_ACK counts as timer value 0. The error is taken at the edge ending the cycle in which the timer equals ACK_TIMEOUT-1.

## Configuration
- `SAMPLE_LINK_PARITY_EN` defined: a PAR state follows D3. It drives `{^latched_byte, 1'b0}`, even parity in bit 1, for one cycle. Frame length becomes 6 driven beats.
- Not defined: there is no PAR state, D3 goes directly to TURN, and the frame is 5 driven beats.

## Structure
- Package `sample_link_pkg` holds:
  - the state enum;
  - symbol constants `SYM_START`=2'b10, `SYM_ACK`=2'b01, `SYM_NAK`=2'b10;
  - error codes `ERR_NAK`=2'b01, `ERR_TIMEOUT`=2'b10.
- One sub-module is natural: `sample_link_ack_timer`. It is a saturating counter with clear, enable, and an `expired` output compared against ACK_TIMEOUT.
- The top level holds the FSM, the byte latch, the retry counter and the tri-state driver.

## Test plan
- Send byte 8'hB4 with the peer ACKing at the first WAIT_ACK sample. Required bus sequence: 10, 10, 11, 01, 00, then Z. `done` pulses at T+8 (parity off). No `err`.
- MAX_RETRY=2 with the peer NAKing twice, then ACKing. Required: three identical frames of 8'h5A, one `done`, no `err`.
- MAX_RETRY=2 with the peer NAKing every time. Required: three frames, then `err`=1 for one cycle with `err_code`=01 and return to IDLE.
- Peer silent (bus reads 00) with ACK_TIMEOUT=16. Required: `err` with `err_code`=10 exactly 16 cycles after WAIT_ACK entry. An ACK in the expiry cycle instead gives `done` and no `err`.
- `rst_n` low during D1. Required: `e` is Z in the same cycle, then IDLE with `tx_ready`=1, no pulses. The next byte is sent normally.
- `SAMPLE_LINK_PARITY_EN` defined, byte 8'h07. Required: a PAR beat of 2'b10 follows D3, and the first ACK sample is at T+8.
